// File: rtl/mac_array_ws.sv
// Weight-stationary systolic MAC array, row x col PEs.
// Activations/instructions enter from the west through per-row skew chains, weights are
// latched once per PE (loaded flag), partial sums flow north to south.
`timescale 1ns/1ps

module mac_array_ws #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [row*bw-1:0]      in_w,
    input  logic [1:0]             inst_w,
    input  logic [col*psum_bw-1:0] in_n,
    input  logic                   clr_w,
    output logic [col*psum_bw-1:0] out_s,
    output logic [col-1:0]         valid,
    output logic                   load_done
);

    // One skew stage carries {inst, activation}.
    localparam int unsigned SW = bw + 2;

    // West-side inputs of each PE and north-side partial sums of each PE.
    logic [bw-1:0]      west_a    [row][col];
    logic [1:0]         west_inst [row][col];
    logic [psum_bw-1:0] north_ps  [row][col];
    logic [row*col-1:0] loaded_vec;

    assign load_done = &loaded_vec;

    for (genvar c = 0; c < col; c++) begin : g_seed
        assign north_ps[0][c] = in_n[c*psum_bw +: psum_bw];
    end

    for (genvar r = 0; r < row; r++) begin : g_row
        // Lane r is delayed by r+1 stages; newest entry sits in the LSBs.
        localparam int unsigned LW = (r + 1) * SW;

        logic [LW-1:0] sk_q, sk_d;

        // Shift the skew chain every cycle regardless of instruction.
        always_comb begin
            sk_d = (sk_q << SW) | LW'({inst_w, in_w[r*bw +: bw]});
        end

        // Skew chain register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sk_q <= '0;
            end else begin
                sk_q <= sk_d;
            end
        end

        assign west_inst[r][0] = sk_q[LW-1 -: 2];
        assign west_a[r][0]    = sk_q[LW-3 -: bw];

        for (genvar c = 0; c < col; c++) begin : g_col
            logic [bw-1:0]             w_q, w_d;
            logic                      loaded_q, loaded_d;
            logic [psum_bw-1:0]        psum_q, psum_d;
            logic [bw-1:0]             wa;
            logic [1:0]                wi;
            logic                      exec;
            logic signed [psum_bw-1:0] w_ext;
            logic [psum_bw-1:0]        a_ext;
            logic [psum_bw-1:0]        prod;

            assign wa    = west_a[r][c];
            assign wi    = west_inst[r][c];
            assign exec  = wi[1];
            // Signed weight times unsigned activation, wrapping at psum_bw.
            assign w_ext = psum_bw'($signed(w_q));
            assign a_ext = psum_bw'(wa);
            assign prod  = w_ext * a_ext;

            // Weight capture, loaded flag (clear wins) and MAC accumulate.
            always_comb begin
                w_d      = w_q;
                loaded_d = loaded_q;
                psum_d   = psum_q;
                if (wi == 2'b01 && !loaded_q) begin
                    w_d      = wa;
                    loaded_d = 1'b1;
                end
                if (clr_w) begin
                    loaded_d = 1'b0;
                end
                if (exec) begin
                    psum_d = north_ps[r][c] + prod;
                end
            end

            // PE weight, loaded flag and partial-sum registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    w_q      <= '0;
                    loaded_q <= 1'b0;
                    psum_q   <= '0;
                end else begin
                    w_q      <= w_d;
                    loaded_q <= loaded_d;
                    psum_q   <= psum_d;
                end
            end

            assign loaded_vec[r*col+c] = loaded_q;

            // Eastward forwarding; the last column has no east neighbour.
            if (c < col - 1) begin : g_fwd
                logic [bw-1:0] a_q, a_d;
                logic [1:0]    inst_q, inst_d;

                // Load bit passes east only once this PE holds its own weight.
                always_comb begin
                    a_d = a_q;
                    if (wi != 2'b00) begin
                        a_d = wa;
                    end
                    inst_d = {wi[1], wi[0] & ~wi[1] & loaded_q};
                end

                // Eastward activation/instruction registers.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        a_q    <= '0;
                        inst_q <= 2'b00;
                    end else begin
                        a_q    <= a_d;
                        inst_q <= inst_d;
                    end
                end

                assign west_a[r][c+1]    = a_q;
                assign west_inst[r][c+1] = inst_q;
            end

            // Only the bottom row's valid is observable, so v_q lives there.
            if (r < row - 1) begin : g_south
                assign north_ps[r+1][c] = psum_q;
            end else begin : g_out
                logic v_q, v_d;

                // Valid follows the execute bit seen this cycle.
                always_comb begin
                    v_d = exec;
                end

                // Output valid register.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        v_q <= 1'b0;
                    end else begin
                        v_q <= v_d;
                    end
                end

                assign out_s[c*psum_bw +: psum_bw] = psum_q;
                assign valid[c]                    = v_q;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_ws.sv
// Self-checking bench for mac_array_ws: directed scenarios plus randomized bursts
// compared against a matrix dot-product model with latency derived from the array shape.
`timescale 1ns/1ps

module tb_mac_array_ws;

    localparam int BW   = 4;
    localparam int PW   = 16;
    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int MAXE = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [ROW*BW-1:0] in_w;
    logic [1:0]        inst_w;
    logic [COL*PW-1:0] in_n;
    logic              clr_w;
    logic [COL*PW-1:0] out_s;
    logic [COL-1:0]    valid;
    logic              load_done;

    mac_array_ws #(
        .bw      (BW),
        .psum_bw (PW),
        .row     (ROW),
        .col     (COL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_w      (in_w),
        .inst_w    (inst_w),
        .in_n      (in_n),
        .clr_w     (clr_w),
        .out_s     (out_s),
        .valid     (valid),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: weight matrix, activations per execute, per-lane seed.
    logic [BW-1:0] wmod [ROW][COL];
    logic [BW-1:0] acts [MAXE][ROW];
    logic [PW-1:0] seed [COL];
    logic          exp_ld;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // out[c] = seed[c] + sum_r signed(W[r][c]) * unsigned(A[r]), mod 2^PW.
    function automatic logic [PW-1:0] expect_lane(int j, int c);
        int acc;
        acc = int'(seed[c]);
        for (int r = 0; r < ROW; r++) begin
            acc += int'($signed(wmod[r][c])) * int'(acts[j][r]);
        end
        return PW'(acc);
    endfunction

    task automatic check_zero_state(input string tag);
        for (int c = 0; c < COL; c++) begin
            chk($sformatf("%s out_s[%0d]", tag, c), out_s[c*PW +: PW], '0);
        end
        chk({tag, " valid"}, PW'(valid), '0);
        chk({tag, " load_done"}, PW'(load_done), '0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        inst_w = 2'b00;
        in_w   = '0;
        in_n   = '0;
        clr_w  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) wmod[r][c] = '0;
        exp_ld = 1'b0;
        #4;
        check_zero_state("reset");
        tick();
    endtask

    // Burst of COL load cycles; word c of lane r is meant for PE(r,c).
    // fresh=1 expects an unloaded array, fresh=0 expects words to be ignored.
    task automatic load_burst(input bit fresh, input bit rnd, input logic [BW-1:0] val);
        logic [BW-1:0] words [ROW][COL];
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
                words[r][c] = rnd ? BW'($urandom_range(0, 15)) : val;
                if (fresh) wmod[r][c] = words[r][c];
            end
        for (int t = 0; t < ROW + 2*COL + 2; t++) begin
            if (t < COL) begin
                inst_w = 2'b01;
                for (int r = 0; r < ROW; r++) in_w[r*BW +: BW] = words[r][t];
            end else begin
                inst_w = 2'b00;
                in_w   = '0;
            end
            #4;
            if (fresh) exp_ld = (t >= ROW + 2*COL - 1);
            chk($sformatf("load t=%0d load_done", t), PW'(load_done), PW'(exp_ld));
            chk($sformatf("load t=%0d valid", t), PW'(valid), '0);
            tick();
        end
    endtask

    // n back-to-back executes; lane c of execute j is due in cycle j+ROW+1+c.
    task automatic exec_burst(input int n, input bit rnd_a, input logic [BW-1:0] aval,
                              input bit rnd_s, input logic [PW-1:0] sval);
        int j;
        for (int e = 0; e < n; e++)
            for (int r = 0; r < ROW; r++)
                acts[e][r] = rnd_a ? BW'($urandom_range(0, 15)) : aval;
        for (int c = 0; c < COL; c++) begin
            seed[c] = rnd_s ? PW'($urandom) : sval;
            in_n[c*PW +: PW] = seed[c];
        end
        for (int t = 0; t < n + ROW + COL + 2; t++) begin
            if (t < n) begin
                inst_w = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
                for (int r = 0; r < ROW; r++) in_w[r*BW +: BW] = acts[t][r];
            end else begin
                inst_w = 2'b00;
                in_w   = '0;
            end
            #4;
            for (int c = 0; c < COL; c++) begin
                j = t - ROW - 1 - c;
                if (j >= 0 && j < n) begin
                    chk($sformatf("exec t=%0d valid[%0d]", t, c), PW'(valid[c]), 16'd1);
                    chk($sformatf("exec t=%0d out_s[%0d]", t, c), out_s[c*PW +: PW],
                        expect_lane(j, c));
                end else begin
                    chk($sformatf("exec t=%0d valid[%0d]", t, c), PW'(valid[c]), '0);
                end
            end
            chk($sformatf("exec t=%0d load_done", t), PW'(load_done), PW'(exp_ld));
            tick();
        end
        in_n = '0;
    endtask

    task automatic pulse_clr();
        clr_w  = 1'b1;
        inst_w = 2'b00;
        #4;
        chk("clr same-cycle load_done", PW'(load_done), PW'(exp_ld));
        tick();
        clr_w  = 1'b0;
        exp_ld = 1'b0;
        #4;
        chk("clr after load_done", PW'(load_done), '0);
        tick();
    endtask

    initial begin
        // Reset state.
        do_reset();

        // Load all-ones, then a single execute with activations 15 -> 120 per lane.
        load_burst(1'b1, 1'b0, 4'h1);
        exec_burst(1, 1'b0, 4'hF, 1'b0, 16'd0);

        // Signed weights -8, activations 15 -> -960 per lane.
        do_reset();
        load_burst(1'b1, 1'b0, 4'b1000);
        exec_burst(1, 1'b0, 4'hF, 1'b0, 16'd0);

        // Seeded streaming: 4 back-to-back executes -> 108 per lane per cycle.
        do_reset();
        load_burst(1'b1, 1'b0, 4'h1);
        exec_burst(4, 1'b0, 4'h1, 1'b0, 16'd100);

        // Reset asserted during the 5th load cycle drops the partial load.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            inst_w = 2'b01;
            in_w   = {ROW{4'h1}};
            tick();
        end
        inst_w = 2'b01;
        in_w   = {ROW{4'h1}};
        reset  = 1'b1;
        #4;
        check_zero_state("midload reset");
        tick();
        reset  = 1'b0;
        inst_w = 2'b00;
        in_w   = '0;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) wmod[r][c] = '0;
        exp_ld = 1'b0;
        tick();
        exec_burst(2, 1'b1, 4'h0, 1'b0, 16'd7);

        // Re-arm: clear keeps weights, reload with 2 -> 16 per lane.
        do_reset();
        load_burst(1'b1, 1'b0, 4'h1);
        pulse_clr();
        exec_burst(2, 1'b1, 4'h0, 1'b1, 16'd0);
        load_burst(1'b1, 1'b0, 4'h2);
        exec_burst(1, 1'b0, 4'h1, 1'b0, 16'd0);

        // Randomized weights, activations and seeds.
        do_reset();
        load_burst(1'b1, 1'b1, 4'h0);
        for (int b = 0; b < 3; b++) begin
            exec_burst($urandom_range(1, MAXE), 1'b1, 4'h0, 1'b1, 16'd0);
        end
        // A load burst on a fully loaded array must leave weights unchanged.
        load_burst(1'b0, 1'b1, 4'h0);
        exec_burst($urandom_range(1, MAXE), 1'b1, 4'h0, 1'b1, 16'd0);
        pulse_clr();
        load_burst(1'b1, 1'b1, 4'h0);
        exec_burst($urandom_range(1, MAXE), 1'b1, 4'h0, 1'b1, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
